// File: rtl/dbus_master_if.sv
`default_nettype none
// ============================================================================
// Module  : dbus_master_if
// Purpose : Command-side and d-bus signal bundle for the dbus_master initiator.
// Rev     : 1.0  initial release
// ============================================================================
interface dbus_master_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  start;
  logic [ADDR_WIDTH+1:0] addr;
  logic [1:0]            size;
  logic                  wr;
  logic                  sign;
  logic [31:0]           wr_data;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [31:0]           rd_data;
  logic                  d_access;
  logic                  d_cs;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [3:0]            d_bytesel;
  logic [31:0]           d_wr_val;
  logic                  d_wr_en;
  logic [31:0]           d_data;
  logic                  d_ack;

  modport master (
    input  start, addr, size, wr, sign, wr_data, d_data, d_ack,
    output busy, done, err, rd_data,
    output d_access, d_cs, d_addr, d_bytesel, d_wr_val, d_wr_en
  );

  modport slave (
    output start, addr, size, wr, sign, wr_data, d_data, d_ack,
    input  busy, done, err, rd_data,
    input  d_access, d_cs, d_addr, d_bytesel, d_wr_val, d_wr_en
  );
endinterface
`default_nettype wire

// File: rtl/dbus_master.sv
`default_nettype none
// ============================================================================
// Module  : dbus_master
// Purpose : Turns an 8/16/32-bit load/store command into one d-bus transaction.
//           Optional WAIT abort counter enabled by defining DBUS_MASTER_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
module dbus_master #(
  parameter int ADDR_WIDTH     = 11,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  wire logic     clk,
  input  wire logic     rst,
  dbus_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_FAULT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [1:0]            r_size;
  logic [1:0]            r_off;
  logic                  r_wr;
  logic                  r_sign;
  logic                  r_err;
  logic [31:0]           r_rd_data;
  logic                  r_d_access;
  logic [ADDR_WIDTH-1:0] r_d_addr;
  logic [3:0]            r_d_bytesel;
  logic [31:0]           r_d_wr_val;
  logic                  r_d_wr_en;

  logic                  w_misaligned;
  logic [3:0]            w_lanes;
  logic [31:0]           w_wr_val;
  logic [31:0]           w_shifted;
  logic [31:0]           w_load;
  logic                  w_timeout;

  // Decode of the incoming command; only consumed on the accept cycle.
  always_comb begin
    w_misaligned = 1'b0;
    w_lanes      = 4'b0000;
    w_wr_val     = bus.wr_data;
    case (bus.size)
      2'b00: begin
        w_lanes  = 4'b0001 << bus.addr[1:0];
        w_wr_val = {4{bus.wr_data[7:0]}};
      end
      2'b01: begin
        w_misaligned = bus.addr[0];
        w_lanes      = bus.addr[1] ? 4'b1100 : 4'b0011;
        w_wr_val     = {2{bus.wr_data[15:0]}};
      end
      2'b10: begin
        w_misaligned = |bus.addr[1:0];
        w_lanes      = 4'b1111;
      end
      default: w_misaligned = 1'b1;
    endcase
  end

  // Aligned accesses keep halves on a 16-bit boundary, so one byte-offset shift serves all sizes.
  always_comb begin
    w_shifted = bus.d_data >> {r_off, 3'b000};
    case (r_size)
      2'b00:   w_load = {{24{r_sign & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load = {{16{r_sign & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = bus.d_data;
    endcase
  end

`ifdef DBUS_MASTER_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_REQ) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = w_misaligned ? S_FAULT : S_REQ;
      S_REQ:   w_next = S_WAIT;
      S_WAIT:  if (bus.d_ack || w_timeout) w_next = S_DONE;
      S_FAULT: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_size      <= 2'b00;
      r_off       <= 2'b00;
      r_wr        <= 1'b0;
      r_sign      <= 1'b0;
      r_err       <= 1'b0;
      r_rd_data   <= 32'h0;
      r_d_access  <= 1'b0;
      r_d_addr    <= '0;
      r_d_bytesel <= 4'b0000;
      r_d_wr_val  <= 32'h0;
      r_d_wr_en   <= 1'b0;
    end else begin
      r_d_access  <= 1'b0;
      r_d_addr    <= '0;
      r_d_bytesel <= 4'b0000;
      r_d_wr_val  <= 32'h0;
      r_d_wr_en   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_size <= bus.size;
            r_off  <= bus.addr[1:0];
            r_wr   <= bus.wr;
            r_sign <= bus.sign;
            if (!w_misaligned) begin
              r_d_access  <= 1'b1;
              r_d_addr    <= bus.addr[ADDR_WIDTH+1:2];
              r_d_bytesel <= w_lanes;
              r_d_wr_val  <= w_wr_val;
              r_d_wr_en   <= bus.wr;
            end
          end
        end
        S_WAIT: begin
          // An ack on the expiry cycle takes precedence over the abort.
          if (bus.d_ack) begin
            r_err <= 1'b0;
            if (!r_wr) r_rd_data <= w_load;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        S_FAULT: r_err <= 1'b1;
        S_DONE:  r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = r_err;
  assign bus.rd_data   = r_rd_data;
  assign bus.d_access  = r_d_access;
  assign bus.d_cs      = r_d_access;
  assign bus.d_addr    = r_d_addr;
  assign bus.d_bytesel = r_d_bytesel;
  assign bus.d_wr_val  = r_d_wr_val;
  assign bus.d_wr_en   = r_d_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_dbus_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_dbus_master
// Purpose : Self-checking bench for dbus_master against a byte-memory reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dbus_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dbus_master_if #(.ADDR_WIDTH(11)) dif ();

  dbus_master #(.ADDR_WIDTH(11), .TIMEOUT_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  ref_bytes [0:8191];
  logic [31:0] slave_mem [0:2047];
  logic [31:0] rd_hold = 32'h0;

  bit          slave_alive = 1'b1;
  bit          force_ack   = 1'b0;
  logic [31:0] force_data  = 32'h0;
  bit          ack_pending = 1'b0;
  logic [31:0] rd_word     = 32'h0;
  int          acc_cnt     = 0;
  int          idle_dirty  = 0;
  logic [10:0] acc_addr;
  logic [3:0]  acc_sel;
  logic [31:0] acc_val;
  logic        acc_wen;

  // Registered-ack slave: sees the request cycle, answers in the following one.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        ack_pending = 1'b0;
        dif.d_ack   = 1'b0;
      end else begin
        if (force_ack) begin
          dif.d_ack  = 1'b1;
          dif.d_data = force_data;
        end else if (ack_pending) begin
          dif.d_ack   = 1'b1;
          dif.d_data  = rd_word;
          ack_pending = 1'b0;
        end else begin
          dif.d_ack  = 1'b0;
          dif.d_data = $urandom;
        end
        if (dif.d_access !== dif.d_cs) idle_dirty++;
        if (dif.d_access === 1'b1) begin
          acc_cnt++;
          acc_addr = dif.d_addr;
          acc_sel  = dif.d_bytesel;
          acc_val  = dif.d_wr_val;
          acc_wen  = dif.d_wr_en;
          if (slave_alive) begin
            for (int l = 0; l < 4; l++) begin
              if (acc_sel[l] && acc_wen) slave_mem[acc_addr][8*l +: 8] = acc_val[8*l +: 8];
            end
            rd_word = $urandom;
            for (int l = 0; l < 4; l++) begin
              if (acc_sel[l]) rd_word[8*l +: 8] = slave_mem[acc_addr][8*l +: 8];
            end
            ack_pending = 1'b1;
          end
        end else if (dif.d_addr !== 11'h0 || dif.d_bytesel !== 4'h0 ||
                     dif.d_wr_val !== 32'h0 || dif.d_wr_en !== 1'b0) begin
          idle_dirty++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd3) ? 4 : (1 << sz);
  endfunction

  function automatic bit ref_misaligned(input int a, input logic [1:0] sz);
    return (sz == 2'd3) || ((a % nbytes(sz)) != 0);
  endfunction

  function automatic logic [3:0] ref_lanes(input int a, input logic [1:0] sz);
    logic [3:0] m = 4'h0;
    for (int i = 0; i < nbytes(sz); i++) m[(a % 4) + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] ref_wrval(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] v;
    for (int l = 0; l < 4; l++) v[8*l +: 8] = wd[8*(l % nbytes(sz)) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] ref_load(input int a, input int n, input bit sg);
    longint v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(ref_bytes[a + i]);
    if (sg && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input int a, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) ref_bytes[a + i] = wd[8*i +: 8];
  endtask

  // Issues one command and collects what the DUT did; callers do the checking.
  task automatic issue(input logic [12:0] a, input logic [1:0] sz, input logic w,
                       input logic sg, input logic [31:0] wd,
                       output int lat, output logic e, output logic [31:0] rd,
                       output int acc, output bit shape_ok);
    int acc0;
    @(negedge clk);
    dif.start = 1'b1; dif.addr = a; dif.size = sz; dif.wr = w; dif.sign = sg; dif.wr_data = wd;
    acc0 = acc_cnt;
    @(posedge clk);
    #1;
    dif.start = 1'b0; dif.addr = 13'($urandom); dif.size = 2'($urandom);
    dif.wr = 1'($urandom); dif.sign = 1'($urandom); dif.wr_data = $urandom;
    lat = 0; shape_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (dif.busy !== 1'b1) shape_ok = 1'b0;
    end while (dif.done !== 1'b1 && lat < 200);
    e  = dif.err;
    rd = dif.rd_data;
    @(negedge clk);
    if (dif.busy !== 1'b0 || dif.done !== 1'b0) shape_ok = 1'b0;
    acc = acc_cnt - acc0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if ({dif.busy, dif.done, dif.err, dif.d_access, dif.d_cs, dif.d_wr_en} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000",
                         {dif.busy, dif.done, dif.err, dif.d_access, dif.d_cs, dif.d_wr_en}); end
    n_cmp++; if (dif.rd_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_rd: got %h want 00000000", dif.rd_data); end
    n_cmp++; if ({dif.d_addr, dif.d_bytesel, dif.d_wr_val} !== 47'h0) begin
      n_fail++; $display("FAIL reset_bus: got %h %h %h want 0", dif.d_addr, dif.d_bytesel, dif.d_wr_val); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (dif.busy !== 1'b0 || dif.done !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: busy %b done %b want 0 0", dif.busy, dif.done); end
  endtask

  typedef struct {
    logic [12:0] a; logic [1:0] sz; logic w; logic sg;
    logic [31:0] wd; logic [31:0] rd; logic [3:0] sel; logic [31:0] val;
  } dcmd_t;

  task automatic test_store_load();
    dcmd_t t [8];
    int lat, acc; logic e; logic [31:0] rd; bit ok;
    t[0] = '{13'h010, 2'd2, 1'b1, 1'b0, 32'hdeadbeef, 32'h0,        4'b1111, 32'hdeadbeef};
    t[1] = '{13'h010, 2'd2, 1'b0, 1'b0, 32'h0,        32'hdeadbeef, 4'b1111, 32'h0};
    t[2] = '{13'h013, 2'd0, 1'b1, 1'b0, 32'h000000a5, 32'hdeadbeef, 4'b1000, 32'ha5a5a5a5};
    t[3] = '{13'h013, 2'd0, 1'b0, 1'b1, 32'h0,        32'hffffffa5, 4'b1000, 32'h0};
    t[4] = '{13'h013, 2'd0, 1'b0, 1'b0, 32'h0,        32'h000000a5, 4'b1000, 32'h0};
    t[5] = '{13'h010, 2'd2, 1'b1, 1'b0, 32'h80011234, 32'h000000a5, 4'b1111, 32'h80011234};
    t[6] = '{13'h012, 2'd1, 1'b0, 1'b1, 32'h0,        32'hffff8001, 4'b1100, 32'h0};
    t[7] = '{13'h010, 2'd1, 1'b0, 1'b0, 32'h0,        32'h00001234, 4'b0011, 32'h0};
    for (int i = 0; i < 8; i++) begin
      if (t[i].w) ref_store(int'(t[i].a), nbytes(t[i].sz), t[i].wd);
      issue(t[i].a, t[i].sz, t[i].w, t[i].sg, t[i].wd, lat, e, rd, acc, ok);
      n_cmp++; if (lat !== 3 || e !== 1'b0 || acc !== 1 || !ok) begin
        n_fail++; $display("FAIL dir_timing[%0d]: lat %0d err %b acc %0d shape %b want 3 0 1 1", i, lat, e, acc, ok); end
      n_cmp++; if (rd !== t[i].rd) begin
        n_fail++; $display("FAIL dir_rd[%0d]: got %h want %h", i, rd, t[i].rd); end
      n_cmp++; if (acc_sel !== t[i].sel || acc_wen !== t[i].w || acc_addr !== t[i].a[12:2]) begin
        n_fail++; $display("FAIL dir_bus[%0d]: sel %b wen %b addr %h want %b %b %h",
                           i, acc_sel, acc_wen, acc_addr, t[i].sel, t[i].w, t[i].a[12:2]); end
      if (t[i].w) begin
        n_cmp++; if (acc_val !== t[i].val) begin
          n_fail++; $display("FAIL dir_wrval[%0d]: got %h want %h", i, acc_val, t[i].val); end
      end
    end
    rd_hold = 32'h00001234;
  endtask

  task automatic test_fault();
    logic [12:0] fa [3] = '{13'h012, 13'h011, 13'h010};
    logic [1:0]  fs [3] = '{2'd2, 2'd1, 2'd3};
    int lat, acc; logic e; logic [31:0] rd; bit ok;
    for (int i = 0; i < 3; i++) begin
      issue(fa[i], fs[i], 1'($urandom), 1'b0, $urandom, lat, e, rd, acc, ok);
      n_cmp++; if (lat !== 2 || e !== 1'b1 || acc !== 0 || !ok) begin
        n_fail++; $display("FAIL fault[%0d]: lat %0d err %b acc %0d shape %b want 2 1 0 1", i, lat, e, acc, ok); end
      n_cmp++; if (rd !== rd_hold) begin
        n_fail++; $display("FAIL fault_rd[%0d]: got %h want %h", i, rd, rd_hold); end
    end
  endtask

  task automatic test_random();
    int lat, acc, a, n; logic e; logic [31:0] rd, wd, exp_rd; bit ok, bad;
    logic [1:0] sz; logic w, sg;
    for (int i = 0; i < 60; i++) begin
      a = $urandom_range(0, 63); sz = 2'($urandom_range(0, 3));
      w = 1'($urandom); sg = 1'($urandom); wd = $urandom;
      bad = ref_misaligned(a, sz);
      n = nbytes(sz);
      exp_rd = rd_hold;
      if (!bad && !w) exp_rd = ref_load(a, n, sg);
      if (!bad && w) ref_store(a, n, wd);
      issue(13'(a), sz, w, sg, wd, lat, e, rd, acc, ok);
      n_cmp++; if (lat !== (bad ? 2 : 3) || e !== bad || acc !== (bad ? 0 : 1) || !ok) begin
        n_fail++; $display("FAIL rnd_timing[%0d]: lat %0d err %b acc %0d shape %b want bad=%b", i, lat, e, acc, ok, bad); end
      n_cmp++; if (rd !== exp_rd) begin
        n_fail++; $display("FAIL rnd_rd[%0d]: a %h sz %0d sg %b got %h want %h", i, a, sz, sg, rd, exp_rd); end
      if (!bad) begin
        n_cmp++; if (acc_sel !== ref_lanes(a, sz) || acc_wen !== w || acc_addr !== 11'(a / 4)) begin
          n_fail++; $display("FAIL rnd_bus[%0d]: sel %b wen %b addr %h want %b %b %h",
                             i, acc_sel, acc_wen, acc_addr, ref_lanes(a, sz), w, a / 4); end
        if (w) begin
          n_cmp++; if (acc_val !== ref_wrval(sz, wd)) begin
            n_fail++; $display("FAIL rnd_wrval[%0d]: got %h want %h", i, acc_val, ref_wrval(sz, wd)); end
        end
      end
      rd_hold = exp_rd;
    end
  endtask

  task automatic test_start_while_busy();
    int lat, acc0; logic [31:0] exp_rd;
    exp_rd = ref_load(16'h014, 4, 1'b0);
    @(negedge clk);
    dif.start = 1'b1; dif.addr = 13'h014; dif.size = 2'd2; dif.wr = 1'b0; dif.sign = 1'b0;
    acc0 = acc_cnt;
    @(posedge clk);
    #1;
    dif.addr = 13'h020; dif.size = 2'd0; dif.wr = 1'b1; dif.wr_data = $urandom;
    lat = 0;
    do begin @(negedge clk); lat++; end while (dif.done !== 1'b1 && lat < 50);
    dif.start = 1'b0;
    n_cmp++; if (lat !== 3 || dif.err !== 1'b0 || dif.rd_data !== exp_rd) begin
      n_fail++; $display("FAIL busy_start: lat %0d err %b rd %h want 3 0 %h", lat, dif.err, dif.rd_data, exp_rd); end
    repeat (3) @(negedge clk);
    n_cmp++; if (acc_cnt - acc0 !== 1 || dif.busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_drop: accesses %0d busy %b want 1 0", acc_cnt - acc0, dif.busy); end
    rd_hold = exp_rd;
  endtask

  task automatic test_stray_ack();
    bit moved = 1'b0;
    force_data = $urandom;
    @(negedge clk);
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (dif.busy !== 1'b0 || dif.done !== 1'b0) moved = 1'b1;
    end
    force_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (moved || dif.rd_data !== rd_hold) begin
      n_fail++; $display("FAIL stray_ack: moved %b rd %h want 0 %h", moved, dif.rd_data, rd_hold); end
  endtask

  task automatic test_reset_in_bus();
    int lat, acc; logic e; logic [31:0] rd, exp_rd; bit ok;
    slave_alive = 1'b0;
    @(negedge clk);
    dif.start = 1'b1; dif.addr = 13'h010; dif.size = 2'd2; dif.wr = 1'b0;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    #2;
    n_cmp++; if (dif.d_access !== 1'b1) begin
      n_fail++; $display("FAIL req_before_rst: d_access %b want 1", dif.d_access); end
    rst = 1'b1;
    #1;
    n_cmp++; if (dif.d_access !== 1'b0 || dif.d_cs !== 1'b0 || dif.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_in_req: access %b cs %b busy %b want 0 0 0", dif.d_access, dif.d_cs, dif.busy); end
    @(negedge clk);
    rst = 1'b0;
    rd_hold = 32'h0;
    @(negedge clk);
    dif.start = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    @(posedge clk);
    #3;
    n_cmp++; if (dif.busy !== 1'b1) begin
      n_fail++; $display("FAIL wait_before_rst: busy %b want 1", dif.busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (dif.d_access !== 1'b0 || dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.rd_data !== 32'h0) begin
      n_fail++; $display("FAIL rst_in_wait: access %b busy %b done %b rd %h want 0 0 0 0",
                         dif.d_access, dif.busy, dif.done, dif.rd_data); end
    @(negedge clk);
    rst = 1'b0;
    slave_alive = 1'b1;
    exp_rd = ref_load(16'h010, 4, 1'b0);
    issue(13'h010, 2'd2, 1'b0, 1'b0, 32'h0, lat, e, rd, acc, ok);
    n_cmp++; if (lat !== 3 || e !== 1'b0 || rd !== exp_rd || acc !== 1) begin
      n_fail++; $display("FAIL after_rst_load: lat %0d err %b rd %h acc %0d want 3 0 %h 1", lat, e, rd, acc, exp_rd); end
    rd_hold = exp_rd;
  endtask

`ifdef DBUS_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int lat, acc; logic e; logic [31:0] rd; bit ok;
    slave_alive = 1'b0;
    issue(13'h020, 2'd2, 1'b0, 1'b0, 32'h0, lat, e, rd, acc, ok);
    n_cmp++; if (lat !== 66 || e !== 1'b1 || rd !== rd_hold || acc !== 1) begin
      n_fail++; $display("FAIL timeout: lat %0d err %b rd %h acc %0d want 66 1 %h 1", lat, e, rd, acc, rd_hold); end
    test_stray_ack();
    force_data = $urandom;
    @(negedge clk);
    dif.start = 1'b1; dif.addr = 13'h020; dif.size = 2'd2; dif.wr = 1'b0;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    repeat (63) @(posedge clk);
    @(negedge clk);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    n_cmp++; if (dif.done !== 1'b0) begin
      n_fail++; $display("FAIL early_abort: done %b want 0", dif.done); end
    @(negedge clk);
    n_cmp++; if (dif.done !== 1'b1 || dif.err !== 1'b0 || dif.rd_data !== force_data) begin
      n_fail++; $display("FAIL ack_on_expiry: done %b err %b rd %h want 1 0 %h", dif.done, dif.err, dif.rd_data, force_data); end
    rd_hold = force_data;
    @(negedge clk);
    slave_alive = 1'b1;
  endtask
`endif

  task automatic test_bus_idle();
    n_cmp++; if (idle_dirty !== 0) begin
      n_fail++; $display("FAIL bus_idle: %0d cycles with non-zero d-bus outside request, want 0", idle_dirty); end
  endtask

  initial begin
    dif.start = 1'b0; dif.addr = '0; dif.size = 2'd0; dif.wr = 1'b0; dif.sign = 1'b0;
    dif.wr_data = 32'h0; dif.d_data = 32'h0; dif.d_ack = 1'b0;
    for (int i = 0; i < 8192; i++) ref_bytes[i] = 8'h0;
    for (int i = 0; i < 2048; i++) slave_mem[i] = 32'h0;
    test_reset();
    test_store_load();
    test_fault();
    test_random();
    test_start_while_busy();
    test_stray_ack();
    test_reset_in_bus();
`ifdef DBUS_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_bus_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
